// File: rtl/tm1638_pkg.sv
// TM1638 command encodings, default sizes and responder state type.
// Shared between the TM1638 initiator and responder.
package tm1638_pkg;

   localparam int TM_LED_BYTES = 16;
   localparam int TM_IN_BYTES  = 4;

   localparam logic [1:0] CMD_NONE    = 2'b00;
   localparam logic [1:0] CMD_DATA    = 2'b01;
   localparam logic [1:0] CMD_DISPLAY = 2'b10;
   localparam logic [1:0] CMD_ADDRESS = 2'b11;

   localparam int BIT_READ  = 1;
   localparam int BIT_FIXED = 2;
   localparam int BIT_ON    = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_WR_DATA,
      ST_RD_DATA,
      ST_IGNORE
   } tm_state_e;

   function automatic logic [1:0] cmd_field(input logic [7:0] cmd);
      return cmd[7:6];
   endfunction

endpackage

// File: rtl/tm1638_responder_if.sv
// Three-wire TM1638 link; dio is split into input, output and output enable.
interface tm1638_responder_if;
   logic sck;
   logic cs;
   logic dio_i;
   logic dio_o;
   logic dio_e;

   modport master (output sck, output cs, output dio_i, input dio_o, input dio_e);
   modport slave  (input sck, input cs, input dio_i, output dio_o, output dio_e);
endinterface

// File: rtl/spi_input_sync.sv
// Synchronizes sck/cs/dio_i into clk and produces single-cycle edge pulses.
module spi_input_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sck,
   input  logic cs,
   input  logic dio_i,
   output logic sck_rise,
   output logic sck_fall,
   output logic cs_rise,
   output logic cs_fall,
   output logic dio_s
);

   logic [SYNC_STAGES-1:0] sck_ff;
   logic [SYNC_STAGES-1:0] cs_ff;
   logic [SYNC_STAGES-1:0] dio_ff;
   logic                   sck_q;
   logic                   cs_q;

   // Idle levels are high, so reset to 1 to avoid false edges at release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_ff <= '1;
         cs_ff  <= '1;
         dio_ff <= '1;
         sck_q  <= 1'b1;
         cs_q   <= 1'b1;
      end else begin
         sck_ff <= {sck_ff[SYNC_STAGES-2:0], sck};
         cs_ff  <= {cs_ff[SYNC_STAGES-2:0], cs};
         dio_ff <= {dio_ff[SYNC_STAGES-2:0], dio_i};
         sck_q  <= sck_ff[SYNC_STAGES-1];
         cs_q   <= cs_ff[SYNC_STAGES-1];
      end
   end

   assign sck_rise = sck_ff[SYNC_STAGES-1] & ~sck_q;
   assign sck_fall = ~sck_ff[SYNC_STAGES-1] & sck_q;
   assign cs_rise  = cs_ff[SYNC_STAGES-1] & ~cs_q;
   assign cs_fall  = ~cs_ff[SYNC_STAGES-1] & cs_q;
   assign dio_s    = dio_ff[SYNC_STAGES-1];

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 peripheral emulator: decodes initiator commands into display memory
// and display control, and shifts key-scan bytes out on read commands.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | cs high, waiting for cs fall
// ST_CMD     | collecting the command byte
// ST_WR_DATA | after address set; each byte goes to display memory
// ST_RD_DATA | shifting key bytes out on sck falling edges
// ST_IGNORE  | frame content ignored until cs rises
module tm1638_responder
   import tm1638_pkg::*;
#(
   parameter int NUM_LED_BYTES = TM_LED_BYTES,
   parameter int IN_BYTES      = TM_IN_BYTES,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                          clk,
   input  logic                          reset_n,
   tm1638_responder_if.slave             bus,
   output logic [NUM_LED_BYTES-1:0][7:0] tm1638_mem,
   output logic                          display_on,
   output logic [2:0]                    brightness,
   input  logic [IN_BYTES-1:0][7:0]      tm1638_keys,
   output logic                          mem_update,
   output logic                          key_read
);

   localparam int RD_BITS = IN_BYTES * 8;
   localparam int RC_W    = $clog2(RD_BITS + 1);

   logic [1:0]         rst_sync;
   logic               rst_n;
   logic               sck_rise, sck_fall, cs_rise, cs_fall, dio_s;
   tm_state_e          state;
   logic [2:0]         bit_cnt;
   logic [6:0]         shift_in;
   logic [7:0]         byte_in;
   logic               rd_mode;
   logic               fixed_mode;
   logic [3:0]         addr;
   logic [RD_BITS-1:0] key_sr;
   logic [RC_W-1:0]    rd_cnt;
   logic               dio_o_q;
   logic               dio_e_q;

   // Reset asserts immediately, releases synchronously to clk.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .sck      (bus.sck),
      .cs       (bus.cs),
      .dio_i    (bus.dio_i),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall),
      .cs_rise  (cs_rise),
      .cs_fall  (cs_fall),
      .dio_s    (dio_s)
   );

   // LSB first: the newest bit enters at the top of the byte.
   assign byte_in = {dio_s, shift_in};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         shift_in   <= '0;
         rd_mode    <= 1'b0;
         fixed_mode <= 1'b0;
         addr       <= '0;
         key_sr     <= '0;
         rd_cnt     <= '0;
         dio_o_q    <= 1'b1;
         dio_e_q    <= 1'b0;
         tm1638_mem <= '0;
         display_on <= 1'b0;
         brightness <= '0;
         mem_update <= 1'b0;
         key_read   <= 1'b0;
      end else begin
         mem_update <= 1'b0;
         key_read   <= 1'b0;
         if (cs_rise) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            dio_e_q <= 1'b0;
            dio_o_q <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (cs_fall) begin
                     state   <= ST_CMD;
                     bit_cnt <= '0;
                  end
               end
               ST_CMD: begin
                  if (sck_rise) begin
                     shift_in <= byte_in[7:1];
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        case (cmd_field(byte_in))
                           CMD_DATA: begin
                              rd_mode    <= byte_in[BIT_READ];
                              fixed_mode <= byte_in[BIT_FIXED];
                              if (byte_in[BIT_READ]) begin
                                 key_sr   <= tm1638_keys;
                                 key_read <= 1'b1;
                                 rd_cnt   <= '0;
                                 state    <= ST_RD_DATA;
                              end else begin
                                 state <= ST_IGNORE;
                              end
                           end
                           CMD_DISPLAY: begin
                              display_on <= byte_in[BIT_ON];
                              brightness <= byte_in[2:0];
                              state      <= ST_IGNORE;
                           end
                           CMD_ADDRESS: begin
                              addr  <= byte_in[3:0];
                              state <= ST_WR_DATA;
                           end
                           default: state <= ST_IGNORE;
                        endcase
                     end
                  end
               end
               ST_WR_DATA: begin
                  if (sck_rise) begin
                     shift_in <= byte_in[7:1];
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7 && !rd_mode) begin
                        tm1638_mem[addr] <= byte_in;
                        mem_update       <= 1'b1;
                        if (!fixed_mode) addr <= addr + 4'd1;
                     end
                  end
               end
               ST_RD_DATA: begin
                  if (sck_fall && rd_cnt != RC_W'(RD_BITS)) begin
                     dio_e_q <= 1'b1;
                     dio_o_q <= key_sr[0];
                     key_sr  <= key_sr >> 1;
                     rd_cnt  <= rd_cnt + RC_W'(1);
                  end else if (sck_rise && rd_cnt == RC_W'(RD_BITS)) begin
                     dio_e_q <= 1'b0;
                     dio_o_q <= 1'b1;
                     state   <= ST_IGNORE;
                  end
               end
               ST_IGNORE: ;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.dio_o = dio_o_q;
   assign bus.dio_e = dio_e_q;

endmodule
